// File: rtl/gemm_result_pkg.sv
// Shared types for the GEMM result path: FP16 lanes, packed result lines and the drain FSM encoding.
// The result BRAM writer imports this package too.
package gemm_result_pkg;

  localparam int FP16_PER_LINE = 16;

  typedef logic [15:0] fp16_t;
  typedef fp16_t [FP16_PER_LINE-1:0] fp16_line_t;

  typedef enum logic [1:0] {
    DRN_IDLE = 2'd0,
    DRN_RUN  = 2'd1,
    DRN_DONE = 2'd2
  } drain_state_e;

  // Lane 0 occupies bits [15:0] of the line.
  function automatic fp16_t lane_select(input fp16_line_t line, input logic [3:0] lane);
    return line[lane];
  endfunction

endpackage

// File: rtl/result_line_fifo.sv
// Two-entry line FIFO that decouples BRAM read returns from the FP16 unpacker.
// A push and a pop in the same cycle are legal even when the FIFO is full.
module result_line_fifo #(
  parameter int WIDTH = 256
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count,
  output logic             o_empty,
  output logic             o_full
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualified push/pop and status flags.
  always_comb begin
    do_pop_s  = i_pop && (count_r != 2'd0);
    do_push_s = i_push && ((count_r != 2'd2) || do_pop_s);
    o_empty   = (count_r == 2'd0);
    o_full    = (count_r == 2'd2);
    o_count   = count_r;
    o_head    = mem_r[rd_ptr_r];
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, do_push_s} - {1'b0, do_pop_s};
    end
  end

  // Line storage; contents are don't-care while the slot is empty.
  always_ff @(posedge i_clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= i_push_data;
    end
  end

endmodule

// File: rtl/result_line_fifo_chk.sv
// Simulation checker for the line FIFO: the read-credit scheme must never let a return overflow it.
module result_line_fifo_chk (
  input logic i_clk,
  input logic i_reset,
  input logic i_push,
  input logic i_pop,
  input logic i_full
);

  // A push into a full FIFO without a matching pop would drop a line.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset) !(i_push && i_full && !i_pop));

endmodule

// File: rtl/result_bram_drainer.sv
// Drains packed FP16 result lines from the result BRAM and replays them as a valid/ready FP16 stream,
// hiding BRAM read latency with a credit-limited 2-line FIFO.
module result_bram_drainer
  import gemm_result_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = 9,
  parameter int BRAM_DATA_WIDTH = 256,
  parameter int RD_LATENCY      = 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [BRAM_ADDR_WIDTH-1:0] i_base_addr,
  input  logic [BRAM_ADDR_WIDTH:0]   i_num_lines,
  output logic                       o_bram_rd_en,
  output logic [BRAM_ADDR_WIDTH-1:0] o_bram_rd_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] i_bram_rd_data,
  output logic [15:0]                o_fp16_data,
  output logic                       o_fp16_valid,
  input  logic                       i_fp16_ready,
  output logic                       o_fp16_last,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [31:0]                o_value_count
);

  localparam logic [1:0] ST_IDLE = DRN_IDLE;
  localparam logic [1:0] ST_RUN  = DRN_RUN;
  localparam logic [1:0] ST_DONE = DRN_DONE;

  logic [1:0]                 state_r;
  logic [BRAM_ADDR_WIDTH-1:0] base_r;
  logic [BRAM_ADDR_WIDTH:0]   num_r;
  logic [BRAM_ADDR_WIDTH:0]   issued_r;
  logic [BRAM_ADDR_WIDTH:0]   popped_r;
  logic [3:0]                 lane_r;
  logic [1:0]                 inflight_r;
  logic [RD_LATENCY-1:0]      strb_pipe_r;
  logic [31:0]                count_r;

  logic [BRAM_DATA_WIDTH-1:0] head_s;
  logic [1:0]                 fifo_count_s;
  logic                       fifo_empty_s;
  logic                       fifo_full_s;
  logic                       rd_en_s;
  logic                       push_s;
  logic                       pop_s;
  logic                       valid_s;
  logic                       hs_s;
  logic                       last_s;

  // Issue credit, stream handshake and last-value detection; all derived from registered state.
  always_comb begin
    valid_s = (state_r == ST_RUN) && !fifo_empty_s;
    hs_s    = valid_s && i_fp16_ready;
    last_s  = valid_s && (lane_r == 4'd15) &&
              (popped_r == (num_r - {{BRAM_ADDR_WIDTH{1'b0}}, 1'b1}));
    pop_s   = hs_s && (lane_r == 4'd15);
    push_s  = strb_pipe_r[RD_LATENCY-1];
    rd_en_s = (state_r == ST_RUN) && (issued_r < num_r) &&
              (({1'b0, fifo_count_s} + {1'b0, inflight_r}) < 3'd2);
  end

  // Output drive; data and address read as zero whenever their strobe is low.
  always_comb begin
    o_bram_rd_en  = rd_en_s;
    o_fp16_valid  = valid_s;
    o_fp16_last   = last_s;
    o_busy        = (state_r == ST_RUN);
    o_done        = (state_r == ST_DONE);
    o_value_count = count_r;
    if (rd_en_s) begin
      o_bram_rd_addr = base_r + issued_r[BRAM_ADDR_WIDTH-1:0];
    end else begin
      o_bram_rd_addr = {BRAM_ADDR_WIDTH{1'b0}};
    end
    if (valid_s) begin
      o_fp16_data = lane_select(head_s, lane_r);
    end else begin
      o_fp16_data = 16'd0;
    end
  end

  // Drain FSM with issue, pop, lane and value counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r  <= ST_IDLE;
      base_r   <= {BRAM_ADDR_WIDTH{1'b0}};
      num_r    <= {(BRAM_ADDR_WIDTH+1){1'b0}};
      issued_r <= {(BRAM_ADDR_WIDTH+1){1'b0}};
      popped_r <= {(BRAM_ADDR_WIDTH+1){1'b0}};
      lane_r   <= 4'd0;
      count_r  <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            base_r   <= i_base_addr;
            num_r    <= i_num_lines;
            issued_r <= {(BRAM_ADDR_WIDTH+1){1'b0}};
            popped_r <= {(BRAM_ADDR_WIDTH+1){1'b0}};
            lane_r   <= 4'd0;
            count_r  <= 32'd0;
            state_r  <= (i_num_lines == {(BRAM_ADDR_WIDTH+1){1'b0}}) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (rd_en_s) begin
            issued_r <= issued_r + {{BRAM_ADDR_WIDTH{1'b0}}, 1'b1};
          end
          if (hs_s) begin
            count_r <= count_r + 32'd1;
            lane_r  <= lane_r + 4'd1;
            if (pop_s) begin
              popped_r <= popped_r + {{BRAM_ADDR_WIDTH{1'b0}}, 1'b1};
            end
            if (last_s) begin
              state_r <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Reads in flight plus FIFO occupancy form the 2-line credit; reset drops pending returns.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      inflight_r  <= 2'd0;
      strb_pipe_r <= {RD_LATENCY{1'b0}};
    end else begin
      inflight_r     <= inflight_r + {1'b0, rd_en_s} - {1'b0, push_s};
      strb_pipe_r[0] <= rd_en_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        strb_pipe_r[i] <= strb_pipe_r[i-1];
      end
    end
  end

  result_line_fifo #(
    .WIDTH (BRAM_DATA_WIDTH)
  ) u_line_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (push_s),
    .i_push_data (i_bram_rd_data),
    .i_pop       (pop_s),
    .o_head      (head_s),
    .o_count     (fifo_count_s),
    .o_empty     (fifo_empty_s),
    .o_full      (fifo_full_s)
  );

  result_line_fifo_chk u_line_fifo_chk (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push_s),
    .i_pop   (pop_s),
    .i_full  (fifo_full_s)
  );

endmodule

// File: tb/tb_result_bram_drainer.sv
// Scoreboard bench for result_bram_drainer: a RD_LATENCY=1 instance for the main drains and a
// RD_LATENCY=2 instance for the deeper-latency throughput case.
module tb_result_bram_drainer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         a_start, a_rd_en, a_valid, a_ready, a_last, a_busy, a_done;
  logic [8:0]   a_base, a_rd_addr;
  logic [9:0]   a_num;
  logic [255:0] a_rd_data;
  logic [15:0]  a_data;
  logic [31:0]  a_cnt;

  logic         b_start, b_rd_en, b_valid, b_ready, b_last, b_busy, b_done;
  logic [8:0]   b_base, b_rd_addr;
  logic [9:0]   b_num;
  logic [255:0] b_rd_data, b_q1;
  logic [15:0]  b_data;
  logic [31:0]  b_cnt;

  result_bram_drainer #(.BRAM_ADDR_WIDTH(9), .BRAM_DATA_WIDTH(256), .RD_LATENCY(1)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_start(a_start), .i_base_addr(a_base), .i_num_lines(a_num),
    .o_bram_rd_en(a_rd_en), .o_bram_rd_addr(a_rd_addr), .i_bram_rd_data(a_rd_data),
    .o_fp16_data(a_data), .o_fp16_valid(a_valid), .i_fp16_ready(a_ready), .o_fp16_last(a_last),
    .o_busy(a_busy), .o_done(a_done), .o_value_count(a_cnt));

  result_bram_drainer #(.BRAM_ADDR_WIDTH(9), .BRAM_DATA_WIDTH(256), .RD_LATENCY(2)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_start(b_start), .i_base_addr(b_base), .i_num_lines(b_num),
    .o_bram_rd_en(b_rd_en), .o_bram_rd_addr(b_rd_addr), .i_bram_rd_data(b_rd_data),
    .o_fp16_data(b_data), .o_fp16_valid(b_valid), .i_fp16_ready(b_ready), .o_fp16_last(b_last),
    .o_busy(b_busy), .o_done(b_done), .o_value_count(b_cnt));

  // BRAM content: line a, lane l holds 16*a + l.
  logic [255:0] mem [512];
  initial begin
    for (int a = 0; a < 512; a++)
      for (int l = 0; l < 16; l++)
        mem[a][16*l +: 16] = 16'(16*a + l);
  end

  always @(posedge clk) if (a_rd_en) a_rd_data <= mem[a_rd_addr];
  always @(posedge clk) begin
    if (b_rd_en) b_q1 <= mem[b_rd_addr];
    b_rd_data <= b_q1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  logic [16:0] sb_a[$];
  logic [16:0] sb_b[$];
  logic [8:0]  addr_a[$];
  logic [8:0]  addr_b[$];

  task automatic expect_drain(input bit sel_b, input int base, input int num);
    for (int i = 0; i < num; i++) begin
      for (int l = 0; l < 16; l++) begin
        logic [16:0] e;
        e = {(i == num - 1) && (l == 15), 16'(16*((base + i) % 512) + l)};
        if (sel_b) sb_b.push_back(e); else sb_a.push_back(e);
      end
      if (sel_b) addr_b.push_back(9'((base + i) % 512));
      else       addr_a.push_back(9'((base + i) % 512));
    end
  endtask

  int          hs_a = 0, done_cnt_a = 0, done_cyc_a = 0;
  int          done_cnt_b = 0, done_cyc_b = 0;
  logic        stall_a = 1'b0;
  logic [16:0] stall_val_a;

  // Monitor A: scoreboard pop on handshake, stall stability, read address order, done tracking.
  always @(negedge clk) begin
    logic [16:0] e;
    if (stall_a) begin
      chk("stall_valid_hold", {31'd0, a_valid}, 32'd1);
      chk("stall_data_hold", {15'd0, a_last, a_data}, {15'd0, stall_val_a});
    end
    stall_a     = a_valid && !a_ready && !rst;
    stall_val_a = {a_last, a_data};
    if (a_valid && a_ready) begin
      hs_a++;
      if (sb_a.size() == 0) chk("a_unexpected_value", {16'd0, a_data}, 32'hFFFF_FFFF);
      else begin
        e = sb_a.pop_front();
        chk("a_data", {16'd0, a_data}, {16'd0, e[15:0]});
        chk("a_last", {31'd0, a_last}, {31'd0, e[16]});
      end
    end
    if (a_rd_en) begin
      if (addr_a.size() == 0) chk("a_unexpected_read", {23'd0, a_rd_addr}, 32'hFFFF_FFFF);
      else chk("a_rd_addr", {23'd0, a_rd_addr}, {23'd0, addr_a.pop_front()});
    end
    if (a_done) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
  end

  // Monitor B: same scoreboard discipline for the two-cycle-latency instance.
  always @(negedge clk) begin
    logic [16:0] e;
    if (b_valid && b_ready) begin
      if (sb_b.size() == 0) chk("b_unexpected_value", {16'd0, b_data}, 32'hFFFF_FFFF);
      else begin
        e = sb_b.pop_front();
        chk("b_data", {16'd0, b_data}, {16'd0, e[15:0]});
        chk("b_last", {31'd0, b_last}, {31'd0, e[16]});
      end
    end
    if (b_rd_en) begin
      if (addr_b.size() == 0) chk("b_unexpected_read", {23'd0, b_rd_addr}, 32'hFFFF_FFFF);
      else chk("b_rd_addr", {23'd0, b_rd_addr}, {23'd0, addr_b.pop_front()});
    end
    if (b_done) begin
      done_cnt_b++;
      done_cyc_b = cyc;
    end
  end

  int ready_mode = 0;
  initial begin
    a_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 a_ready = (ready_mode == 1) ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  task automatic start_a(input int base, input int num, output int s);
    @(posedge clk);
    #1 a_base = 9'(base); a_num = 10'(num); a_start = 1'b1;
    @(posedge clk);
    #1 s = cyc; a_start = 1'b0;
  endtask

  task automatic wait_done_a(input string nm, input int budget);
    int d0;
    bit seen;
    d0 = done_cnt_a;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      if (done_cnt_a != d0) seen = 1'b1;
    end
    chk(nm, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int s, d0;
    bit seen;
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d0;
    bit seen;
    rst = 1'b1;
    a_start = 1'b0; a_base = 9'd0; a_num = 10'd0;
    b_start = 1'b0; b_base = 9'd0; b_num = 10'd0; b_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", {31'd0, a_rd_en}, 32'd0);
    chk("rst_rd_addr", {23'd0, a_rd_addr}, 32'd0);
    chk("rst_data", {16'd0, a_data}, 32'd0);
    chk("rst_valid", {29'd0, a_valid, a_last, b_valid}, 32'd0);
    chk("rst_busy_done", {28'd0, a_busy, a_done, b_busy, b_done}, 32'd0);
    chk("rst_count", a_cnt, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: full-rate drain of 64 lines
    expect_drain(1'b0, 0, 64);
    start_a(0, 64, s);
    wait_done_a("t1_done_seen", 2000);
    chk("t1_done_latency", 32'(done_cyc_a - s), 32'd1026);
    chk("t1_count", a_cnt, 32'd1024);
    chk("t1_sb_empty", 32'(sb_a.size()), 32'd0);

    // 2: address wrap 510,511,0,1
    expect_drain(1'b0, 510, 4);
    start_a(510, 4, s);
    wait_done_a("t2_done_seen", 200);
    chk("t2_done_latency", 32'(done_cyc_a - s), 32'd66);
    chk("t2_count", a_cnt, 32'd64);
    chk("t2_addr_empty", 32'(addr_a.size()), 32'd0);

    // 3: 30% ready duty
    ready_mode = 1;
    expect_drain(1'b0, 0, 64);
    start_a(0, 64, s);
    wait_done_a("t3_done_seen", 10000);
    ready_mode = 0;
    chk("t3_count", a_cnt, 32'd1024);
    chk("t3_sb_empty", 32'(sb_a.size()), 32'd0);

    // 4: zero-line drain
    repeat (3) @(posedge clk);
    start_a(0, 0, s);
    wait_done_a("t4_done_seen", 10);
    chk("t4_done_window", {31'd0, (done_cyc_a - s) <= 1}, 32'd1);
    chk("t4_count", a_cnt, 32'd0);
    chk("t4_busy", {31'd0, a_busy}, 32'd0);

    // 5: reset mid-drain, then a one-line drain of line 8
    expect_drain(1'b0, 0, 64);
    start_a(0, 64, s);
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(posedge clk);
      if (hs_a >= 200 + 1024 + 64 + 1024) seen = 1'b1;
    end
    chk("t5_reached_200", {31'd0, seen}, 32'd1);
    d0 = done_cnt_a;
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_busy_drop", {31'd0, a_busy}, 32'd0);
    chk("t5_valid_drop", {31'd0, a_valid}, 32'd0);
    sb_a.delete();
    addr_a.delete();
    repeat (4) @(posedge clk);
    chk("t5_no_done", 32'(done_cnt_a - d0), 32'd0);
    expect_drain(1'b0, 8, 1);
    start_a(8, 1, s);
    wait_done_a("t5_done_seen", 100);
    chk("t5_count", a_cnt, 32'd16);
    chk("t5_sb_empty", 32'(sb_a.size()), 32'd0);

    // 6: RD_LATENCY=2, three lines, ignored start mid-run
    expect_drain(1'b1, 0, 3);
    @(posedge clk);
    #1 b_base = 9'd0; b_num = 10'd3; b_start = 1'b1;
    @(posedge clk);
    #1 s = cyc; b_start = 1'b0;
    repeat (10) @(posedge clk);
    #1 b_base = 9'd100; b_num = 10'd5; b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    d0 = done_cnt_b;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      if (done_cnt_b != d0) seen = 1'b1;
    end
    chk("t6_done_seen", {31'd0, seen}, 32'd1);
    chk("t6_done_latency", 32'(done_cyc_b - s), 32'd51);
    chk("t6_count", b_cnt, 32'd48);
    repeat (10) @(posedge clk);
    chk("t6_sb_empty", 32'(sb_b.size()), 32'd0);
    chk("t6_single_done", 32'(done_cnt_b), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
